// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state type and address helpers for the
// data-memory responder.
package dmem_pkg;

    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, DUMP, DONE} dmem_state_t;

    function automatic logic [IDX_W-1:0] word_idx(input logic [N-1:0] a);
        return a[IDX_W+2:3];
    endfunction

    // Any bit above the top word's byte range means the access misses the array.
    function automatic logic in_range(input logic [N-1:0] a);
        return (a[N-1:IDX_W+3] == '0);
    endfunction

endpackage

// File: rtl/dmem_dump_fsm.sv
// dmem_dump_fsm: walks every word index once and presents it on a
// valid/ready port, starting on a rising edge of the dump request.
module dmem_dump_fsm
    import dmem_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_dump,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [N-1:0]     o_addr,
    output logic             o_done,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_idx
);

    dmem_state_t      r_state;
    dmem_state_t      w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_dump_q;
    logic             w_start;
    logic             w_valid;

    assign w_start = i_dump & ~r_dump_q;
    assign w_valid = (r_state == DUMP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_dump_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_dump_q <= i_dump;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = DUMP;
                    w_idx_nxt   = '0;
                end
            end
            DUMP: begin
                if (i_ready) begin
                    if (r_idx == IDX_W'(DEPTH - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (!i_dump) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_valid = w_valid;
    assign o_addr  = w_valid ? N'({r_idx, 3'b000}) : '0;
    assign o_done  = (r_state == DONE);
    assign o_busy  = (r_state != IDLE);
    assign o_idx   = r_idx;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: doubleword data memory with zero-latency reads and a dump port.
// Defining DMEM_ALIGN_CHECK_EN rejects misaligned accesses and flags align_err.
module dmem_responder
    import dmem_pkg::*;
(
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         memWrite,
    input  logic         memRead,
    input  logic [N-1:0] address,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    input  logic         dump,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_done,
    output logic         busy,
    output logic         align_err,
    output logic         range_err
);

    logic [N-1:0]     r_mem [DEPTH];
    logic             r_range_err;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_dump_idx;
    logic             w_in_range;
    logic             w_misalign;
    logic             w_access;
    logic             w_wr_en;
    logic             w_rd_ok;

    assign w_idx      = word_idx(address);
    assign w_in_range = in_range(address);
    assign w_access   = memWrite | memRead;

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_align_err;

    assign w_misalign = |address[2:0];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_align_err <= 1'b0;
        end else if (w_access && w_misalign) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`else
    logic w_unused_lsb;

    assign w_unused_lsb = ^address[2:0];
    assign w_misalign   = 1'b0;
    assign align_err    = 1'b0;
`endif

    // The array is frozen while the dump walker owns it.
    assign w_wr_en = memWrite & ~busy & w_in_range & ~w_misalign;
    assign w_rd_ok = memRead & w_in_range & ~w_misalign;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[w_idx] <= writeData;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_range_err <= 1'b0;
        end else if (w_access && !w_in_range) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
    assign readData  = w_rd_ok ? r_mem[w_idx] : '0;
    assign dump_data = dump_valid ? r_mem[w_dump_idx] : '0;

    dmem_dump_fsm u_dump_fsm (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_dump  (dump),
        .i_ready (dump_ready),
        .o_valid (dump_valid),
        .o_addr  (dump_addr),
        .o_done  (dump_done),
        .o_busy  (busy),
        .o_idx   (w_dump_idx)
    );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder on the processor's data-memory port: accepts memWrite/memRead from the core with a byte address and 64-bit data, stores DEPTH doubleword entries, and answers reads combinationally so the single-cycle datapath can use the result in the same cycle. A dump request walks the whole array and streams every word out over a valid/ready port for the bench or a host to capture. It sits beside processor_arm, at the other end of the DM_addr/DM_writeData/DM_writeEnable/dump interface.

Parameters:
N, 64, data and address width in bits
DEPTH, 32, number of N-bit words (power of 2)
IDX_W, $clog2(DEPTH), word-index width (derived, not overridden)

Ports:
CLOCK_50  in  1  single clock, rising edge
reset  in  1  synchronous reset, active-high
memWrite  in  1  write strobe from core
memRead  in  1  read strobe from core
address  in  N  byte address; word index = address[IDX_W+2:3]
writeData  in  N  write data
readData  out  N  read data, combinational
dump  in  1  dump request, level; a rising edge starts a dump
dump_valid  out  1  dump word is presented
dump_ready  in  1  consumer accepts the dump word
dump_addr  out  N  byte address of the presented word (index*8)
dump_data  out  N  contents of the presented word
dump_done  out  1  all words emitted; held until dump drops
busy  out  1  FSM not in IDLE
align_err  out  1  sticky: misaligned access seen (see Optional Feature)
range_err  out  1  sticky: address beyond DEPTH*8-1

Behaviour:
- Reset (synchronous, any state, including mid-dump): all words cleared to 0; FSM goes to IDLE; index cleared to 0; dump_q cleared to 0; align_err and range_err cleared.
- Outputs after reset: readData=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0, busy=0.
- In range: address[N-1:IDX_W+3]==0. An out-of-range write is dropped. An out-of-range read returns 0. Either one sets range_err.
- Write: when memWrite=1, state=IDLE and the address is in range, mem[idx] takes writeData at the clock edge.
- memWrite while busy=1 is dropped, with no error flag. The memory is frozen during a dump.
- Read: readData = mem[idx] when memRead=1 and the address is in range, else 0. Zero latency.
- A write and a read to the same index in the same cycle return the old value. The new value is visible the next cycle.
- dump_q is a registered copy of dump. start = dump & ~dump_q.
- FSM states IDLE, DUMP, DONE:
  - IDLE -> DUMP on start; index=0.
  - In DUMP: dump_valid=1, dump_addr={index,3'b000} zero-extended, dump_data=mem[index].
  - On dump_valid & dump_ready: if index==DEPTH-1, go to DONE; else index+1.
  - While dump_ready=0, dump_addr and dump_data hold stable.
  - In DONE: dump_done=1, dump_valid=0. DONE -> IDLE when dump=0.
  - A new rising edge of dump is ignored outside IDLE.
- dump_valid is never asserted in IDLE or DONE.
- If dump drops during DUMP, the dump continues to completion, then DONE -> IDLE on the next cycle.
- Exactly DEPTH handshakes occur per dump, in index order 0..DEPTH-1, with no repeats and no skips.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: an access with address[2:0]!=0 and memWrite or memRead set is misaligned. Misaligned writes are dropped, misaligned reads return 0, and either sets align_err.
- Undefined: address[2:0] is ignored (truncated to the word) and align_err is tied to 0.

Decomposition:
- Package dmem_pkg:
  - localparams N and DEPTH.
  - typedef enum logic [1:0] {IDLE, DUMP, DONE} dmem_state_t.
  - Function word_idx(address).
  - Function in_range(address).
- Sub-module dmem_dump_fsm:
  - Owns dump_q, the state register, the index counter and the dump_* handshake.
  - Outputs the index to the array.
  - The parent holds the storage, the read mux and the error flags.

Test Plan:
- Reset, then write 0x00000000000000AB at address 0x10 -> next cycle, memRead at 0x10 gives readData=0xAB; a read of 0x18 gives 0.
- Write 0x1 at 0x8 and, in the same cycle, read 0x8 -> readData=0 that cycle; 0x1 the following cycle.
- Write at 0x100 (DEPTH=32) -> dropped, range_err=1; a read of 0x100 gives 0.
- Preload words 0..31 with value=index+1, pulse dump, dump_ready=1 -> 32 beats: dump_addr=0x0..0xF8, dump_data=1..32, then dump_done=1 until dump=0.
- During a dump, toggle dump_ready 1,0,0,1 on beat 5 -> dump_addr=0x28 and dump_data=6 held across the stall. A concurrent memWrite at 0x0 of 0xFF does not change word 0 after the dump.
- Assert reset at beat 10 of a dump -> next cycle busy=0, dump_valid=0 and all words read 0. With DMEM_ALIGN_CHECK_EN, a write at 0x9 sets align_err and does not modify word 1.
